// File: rtl/rpt_res_return.sv
// rpt_res_return: return path of the report buffer-ID allocator.
// Allocations are snooped into an in-order queue of buf_ids. Completions
// may arrive in any order and are parked in their slot. Reports leave in
// allocation order, and once a report is accepted the slot's rpt_id is
// handed back to the allocator with a one-cycle clear pulse.
//
// Handshake: a report transfers on a rising clk edge where rpt_vld and
// rpt_rdy are both 1. Once rpt_vld rises, it and the payload stay
// unchanged until that transfer. rpt_rdy has no effect while rpt_vld is 0.
module rpt_res_return #(
   parameter int NUM_BUF = 8,
   parameter int RPT_W   = 3,
   parameter int RES_W   = 3,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_vld,
   input  logic [2:0]        alloc_buf_id,
   input  logic [RPT_W-1:0]  alloc_rpt_id,
   input  logic [RES_W-1:0]  alloc_res_id,
   input  logic              cpl_vld,
   input  logic [2:0]        cpl_buf_id,
   input  logic [DATA_W-1:0] cpl_data,
   output logic              rpt_vld,
   input  logic              rpt_rdy,
   output logic [RPT_W-1:0]  rpt_id,
   output logic [RES_W-1:0]  rpt_res_id,
   output logic [DATA_W-1:0] rpt_data,
   output logic              clear,
   output logic [RPT_W-1:0]  clr_rpt_id,
   output logic [3:0]        pend_cnt,
   output logic [2:0]        err
);

   localparam int ID_W  = 3;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BUF);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_SEND    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Order queue of buf_ids, oldest at rd_ptr.
   logic [ID_W-1:0]  q_mem [NUM_BUF];
   logic [ID_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;

   // Per-slot bookkeeping.
   logic [NUM_BUF-1:0] pending, done;
   logic [RPT_W-1:0]   meta_rpt [NUM_BUF];
   logic [RES_W-1:0]   meta_res [NUM_BUF];
   logic [DATA_W-1:0]  data_mem [NUM_BUF];

   // Registered "head slot has its completion" flag; WAIT acts on it.
   logic head_rdy;

   logic [ID_W-1:0] head_id;
   logic            pop;
   logic            q_full;
   logic            alloc_pend;
   logic            alloc_ok;
   logic            cpl_ok;

   // Decode this cycle's events; a pop in RELEASE frees both a queue entry
   // and the head slot before any same-cycle allocation is judged.
   always_comb begin
      head_id    = q_mem[rd_ptr];
      pop        = (state == S_RELEASE);
      q_full     = (count == CNT_FULL) && !pop;
      alloc_pend = pending[alloc_buf_id] && !(pop && (alloc_buf_id == head_id));
      alloc_ok   = alloc_vld && !q_full && !alloc_pend;
      cpl_ok     = cpl_vld && pending[cpl_buf_id] && !done[cpl_buf_id]
                   && !(pop && (cpl_buf_id == head_id));
   end

   // Queue pointers, entries and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < NUM_BUF; i++) begin
            q_mem[i] <= '0;
         end
      end else begin
         if (alloc_ok) begin
            q_mem[wr_ptr] <= alloc_buf_id;
            wr_ptr        <= wr_ptr + ID_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ID_W'(1);
         end
         case ({alloc_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot flags: release clears the head, a new allocation sets pending,
   // an accepted completion sets done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         done    <= '0;
      end else begin
         if (pop) begin
            pending[head_id] <= 1'b0;
            done[head_id]    <= 1'b0;
         end
         if (alloc_ok) begin
            pending[alloc_buf_id] <= 1'b1;
            done[alloc_buf_id]    <= 1'b0;
         end
         if (cpl_ok) begin
            done[cpl_buf_id] <= 1'b1;
         end
      end
   end

   // Slot payload storage: metadata at allocation, data at completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BUF; i++) begin
            meta_rpt[i] <= '0;
            meta_res[i] <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         if (alloc_ok) begin
            meta_rpt[alloc_buf_id] <= alloc_rpt_id;
            meta_res[alloc_buf_id] <= alloc_res_id;
         end
         if (cpl_ok) begin
            data_mem[cpl_buf_id] <= cpl_data;
         end
      end
   end

   // Sticky error flags and the head-ready pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= '0;
         head_rdy <= 1'b0;
      end else begin
         if (alloc_vld && q_full) begin
            err[0] <= 1'b1;
         end
         if (cpl_vld && !cpl_ok) begin
            err[1] <= 1'b1;
         end
         if (alloc_vld && !q_full && alloc_pend) begin
            err[2] <= 1'b1;
         end
         head_rdy <= pending[head_id] && done[head_id] && (count != '0);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: wait for the head's completion, send it, release it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (count != '0) state_nxt = S_WAIT;
         S_WAIT:    if (head_rdy)    state_nxt = S_SEND;
         S_SEND:    if (rpt_rdy)     state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: payload only while sending, clear only while releasing.
   always_comb begin
      rpt_vld    = 1'b0;
      rpt_id     = '0;
      rpt_res_id = '0;
      rpt_data   = '0;
      clear      = 1'b0;
      clr_rpt_id = '0;
      case (state)
         S_SEND: begin
            rpt_vld    = 1'b1;
            rpt_id     = meta_rpt[head_id];
            rpt_res_id = meta_res[head_id];
            rpt_data   = data_mem[head_id];
         end
         S_RELEASE: begin
            clear      = 1'b1;
            clr_rpt_id = meta_rpt[head_id];
         end
         default: begin
            rpt_vld = 1'b0;
         end
      endcase
   end

   // Occupancy as seen after each edge.
   always_comb begin
      pend_cnt = count;
   end

endmodule
